// File: rtl/difftest_log_event.sv
// ---------------------------------------------------------------------------
// difftest_log_event
//
// Named performance-event sampler for difftest builds. It watches a
// free-running event counter. Every PERIOD cycles it records how many events
// arrived since the previous sample. It also keeps the peak per-interval count
// and a saturating count of the samples taken. It is used for simulation and
// debug only and has no side effects on the core.
//
// Parameters:
//   NAME    event name, used only in log output
//   WIDTH   width of the watched counter, the delta and the captured value
//   PERIOD  sample interval in clock cycles (>= 2)
//   SCNT_W  width of the saturating sample counter
//
// Ports:
//   clk           in   clock, rising-edge
//   rst           in   synchronous active-high reset
//   value         in   WIDTH   current event-counter value (mod 2^WIDTH)
//   sample_valid  out  1       one-cycle pulse when a new sample is presented
//   sample_delta  out  WIDTH   events counted in the last completed interval
//   last_value    out  WIDTH   value captured at the last sample point
//   max_delta     out  WIDTH   largest sample_delta since reset
//   sample_count  out  SCNT_W  samples taken, saturating at all-ones
//
// Optional feature (macro DIFFTEST_LOG_EVENT_PRINT_EN):
//   When the macro is defined, the block prints one "[perf]" line for each
//   sample and a total line from a final block. When it is undefined, the
//   block has no printing at all. Register behaviour is the same either way.
// ---------------------------------------------------------------------------
module difftest_log_event #(
    parameter string NAME   = "event",
    parameter int    WIDTH  = 32,
    parameter int    PERIOD = 1024,
    parameter int    SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    output logic              sample_valid,
    output logic [WIDTH-1:0]  sample_delta,
    output logic [WIDTH-1:0]  last_value,
    output logic [WIDTH-1:0]  max_delta,
    output logic [SCNT_W-1:0] sample_count
);

    localparam int CYC_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PERIOD - 1);

    if (PERIOD < 2) begin : gBadPeriod
        $error("difftest_log_event %s: PERIOD must be at least 2", NAME);
    end

    // Event deltas are unsigned modular differences. A counter that wraps
    // between samples still gives the true positive count. A counter that
    // goes backwards is treated the same way and shows up as a huge delta.
    function automatic logic [WIDTH-1:0] wrapDelta(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prev);
        return cur - prev;
    endfunction

    // The sample count holds at all-ones rather than rolling back to zero.
    function automatic logic [SCNT_W-1:0] satInc(input logic [SCNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // The peak is replaced only when a strictly larger delta is seen.
    function automatic logic [WIDTH-1:0] peak(input logic [WIDTH-1:0] d,
                                              input logic [WIDTH-1:0] m);
        return (d > m) ? d : m;
    endfunction

    // The declaration initialisers match the reset values. With rst tied
    // low, the block starts as if it had been reset at time zero.
    logic [CYC_W-1:0]  cyc            = '0;
    logic              vld_p1         = 1'b0;
    logic [WIDTH-1:0]  sampleDelta_p1 = '0;
    logic [WIDTH-1:0]  lastValue_p1   = '0;
    logic [WIDTH-1:0]  maxDelta_p1    = '0;
    logic [SCNT_W-1:0] sampleCount_p1 = '0;

    logic              samplePoint;
    logic [WIDTH-1:0]  delta_p0;

    // ---- stage p0: interval timing and delta against the previous capture
    assign samplePoint = (cyc == CYC_LAST);
    assign delta_p0    = wrapDelta(value, lastValue_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc <= '0;
        end else if (samplePoint) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + 1'b1;
        end
    end

    // ---- stage p1: sample registers, updated only at the sample point
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1         <= 1'b0;
            sampleDelta_p1 <= '0;
            lastValue_p1   <= '0;
            maxDelta_p1    <= '0;
            sampleCount_p1 <= '0;
        end else begin
            vld_p1 <= samplePoint;
            if (samplePoint) begin
                sampleDelta_p1 <= delta_p0;
                lastValue_p1   <= value;
                maxDelta_p1    <= peak(delta_p0, maxDelta_p1);
                sampleCount_p1 <= satInc(sampleCount_p1);
            end
        end
    end

    assign sample_valid = vld_p1;
    assign sample_delta = sampleDelta_p1;
    assign last_value   = lastValue_p1;
    assign max_delta    = maxDelta_p1;
    assign sample_count = sampleCount_p1;

`ifdef DIFFTEST_LOG_EVENT_PRINT_EN
    // Report each sample while it is being presented on the outputs.
    always @(posedge clk) begin
        if (vld_p1) begin
            $display("[perf] %s #%0d delta=%0d max=%0d",
                     NAME, sampleCount_p1, sampleDelta_p1, maxDelta_p1);
        end
    end

    final begin
        $display("[perf] %s total=%0d max=%0d", NAME, lastValue_p1, maxDelta_p1);
    end
`else
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
module tb_difftest_log_event;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value = '0;
    logic        sample_valid;
    logic [31:0] sample_delta;
    logic [31:0] last_value;
    logic [31:0] max_delta;
    logic [1:0]  sample_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    difftest_log_event #(
        .NAME("tb_evt"),
        .WIDTH(32),
        .PERIOD(4),
        .SCNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .sample_valid(sample_valid),
        .sample_delta(sample_delta),
        .last_value(last_value),
        .max_delta(max_delta),
        .sample_count(sample_count)
    );

    typedef struct {
        logic        rstFirst;
        logic [31:0] start;
        logic [31:0] step;
        logic [31:0] expDelta;
        logic [31:0] expLast;
        logic [31:0] expMax;
        logic [1:0]  expCount;
    } vec_t;

    typedef struct {
        logic [31:0] delta;
        logic [31:0] last;
        logic [31:0] max;
        logic [1:0]  count;
    } exp_t;

    exp_t sbQ[$];
    exp_t got;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkZero(input string tag);
        chk({tag, ".valid"}, {31'd0, sample_valid}, 32'd0);
        chk({tag, ".delta"}, sample_delta, 32'd0);
        chk({tag, ".last"},  last_value,   32'd0);
        chk({tag, ".max"},   max_delta,    32'd0);
        chk({tag, ".count"}, {30'd0, sample_count}, 32'd0);
    endtask

    task automatic doReset();
        rst   = 1'b1;
        value = '0;
        tick();
        checkZero("rst1");
        tick();
        checkZero("rst2");
        rst = 1'b0;
    endtask

    // One full interval of four edges. The value presented before the fourth
    // edge is the one captured. The pulse must appear only after that edge.
    task automatic runInterval(input vec_t v);
        exp_t e;
        e.delta = v.expDelta;
        e.last  = v.expLast;
        e.max   = v.expMax;
        e.count = v.expCount;
        sbQ.push_back(e);
        for (int k = 0; k < 4; k++) begin
            value = v.start + v.step * k;
            tick();
            chk("pulse_timing", {31'd0, sample_valid}, (k == 3) ? 32'd1 : 32'd0);
        end
    endtask

    // Scoreboard: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (sample_valid) begin
            if (sbQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse actual=1 required=0 at %0t", $time);
            end else begin
                got = sbQ.pop_front();
                chk("sb.delta", sample_delta, got.delta);
                chk("sb.last",  last_value,   got.last);
                chk("sb.max",   max_delta,    got.max);
                chk("sb.count", {30'd0, sample_count}, {30'd0, got.count});
            end
        end
    end

    initial begin
        //          rst   start          step  delta          last           max            cnt
        tbl[0]  = '{1'b1, 32'd0,         32'd0, 32'd0,         32'd0,         32'd0,         2'd1};
        tbl[1]  = '{1'b0, 32'd0,         32'd0, 32'd0,         32'd0,         32'd0,         2'd2};
        tbl[2]  = '{1'b1, 32'd1,         32'd1, 32'd4,         32'd4,         32'd4,         2'd1};
        tbl[3]  = '{1'b0, 32'd5,         32'd1, 32'd4,         32'd8,         32'd4,         2'd2};
        tbl[4]  = '{1'b0, 32'd9,         32'd1, 32'd4,         32'd12,        32'd4,         2'd3};
        tbl[5]  = '{1'b1, 32'd3,         32'd0, 32'd3,         32'd3,         32'd3,         2'd1};
        tbl[6]  = '{1'b0, 32'd13,        32'd0, 32'd10,        32'd13,        32'd10,        2'd2};
        tbl[7]  = '{1'b0, 32'd15,        32'd0, 32'd2,         32'd15,        32'd10,        2'd3};
        tbl[8]  = '{1'b0, 32'd25,        32'd0, 32'd10,        32'd25,        32'd10,        2'd3};
        tbl[9]  = '{1'b0, 32'd26,        32'd0, 32'd1,         32'd26,        32'd10,        2'd3};
        tbl[10] = '{1'b0, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFE4, 32'hFFFF_FFFE, 32'hFFFF_FFE4, 2'd3};
        tbl[11] = '{1'b0, 32'd3,         32'd0, 32'd5,         32'd3,         32'hFFFF_FFE4, 2'd3};
        tbl[12] = '{1'b0, 32'd7,         32'd0, 32'd7,         32'd7,         32'd7,         2'd1};

        // Power-up state before any clock edge.
        #1;
        checkZero("powerup");

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rstFirst) doReset();
            runInterval(tbl[i]);
        end

        // Reset lands on a sample point. The pulse must be suppressed and the
        // next pulse must come a full period after rst drops.
        value = 32'd100;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pre_rst_valid", {31'd0, sample_valid}, 32'd0);
        end
        rst = 1'b1;
        tick();
        checkZero("rst_at_sample");
        rst = 1'b0;
        runInterval(tbl[12]);

        tick();
        chk("after_valid", {31'd0, sample_valid}, 32'd0);
        chk("sb_empty", sbQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
